// File: rtl/data_mem_responder_if.sv
// Data-memory port between the single-cycle core (master) and its responder (slave).
// ReadData is combinational from the responder back to the core.
interface data_mem_responder_if;
  logic        MemWrite;
  logic [31:0] ALUOut;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, output ALUOut, output WriteData, input ReadData);
  modport slave  (input MemWrite, input ALUOut, input WriteData, output ReadData);
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus memory-mapped LED, cycle counter, compare timer
// and sticky address-error flag. Reads are combinational and never change state.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [15:0] IO_BASE     = 16'hFFFF
) (
  input  logic                 CLK,
  input  logic                 RST,
  data_mem_responder_if.slave  bus,
  output logic [15:0]          LED,
  output logic                 TimerIRQ,
  output logic                 AddrErr
);
  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS) << 2;

  typedef enum logic [2:0] {
    IO_LED, IO_CYCLE, IO_TCMP, IO_TCTRL, IO_TCOUNT, IO_STATUS, IO_NONE
  } io_reg_e;

  logic [31:0] mem [DEPTH_WORDS];

  logic [15:0] led_q;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic [31:0] tcount_q, tcount_d;
  logic        en_q, en_d, pend_q, pend_d, auto_q, auto_d;
  logic        addr_err_q, addr_err_d;
  logic [15:0] led_d;

  io_reg_e     io_sel;
  logic        ram_hit, io_hit, aligned, wr_ok, bad_wr, wr_io, wr_ram, match;
  logic [AW-1:0] ram_idx;
  logic [31:0] wd;

  assign wd      = bus.WriteData;
  assign ram_idx = bus.ALUOut[AW+1:2];
  assign ram_hit = bus.ALUOut < RAM_BYTES;
  assign io_hit  = !ram_hit && (bus.ALUOut[31:16] == IO_BASE);
  assign aligned = bus.ALUOut[1:0] == 2'b00;

  always_comb begin
    io_sel = IO_NONE;
    case (bus.ALUOut[15:2])
      14'd0:   io_sel = IO_LED;
      14'd1:   io_sel = IO_CYCLE;
      14'd2:   io_sel = IO_TCMP;
      14'd3:   io_sel = IO_TCTRL;
      14'd4:   io_sel = IO_TCOUNT;
      14'd5:   io_sel = IO_STATUS;
      default: io_sel = IO_NONE;
    endcase
  end

  assign wr_ok  = bus.MemWrite && aligned && (ram_hit || (io_hit && io_sel != IO_NONE));
  assign bad_wr = bus.MemWrite && !wr_ok;
  assign wr_io  = wr_ok && io_hit;
  assign wr_ram = wr_ok && ram_hit;
  assign match  = en_q && (tcount_q == tcmp_q);

  // Timer action first, then any register write overrides it; PEND/AddrErr sets win over clears.
  always_comb begin
    led_d      = led_q;
    cycle_d    = cycle_q + 32'd1;
    tcmp_d     = tcmp_q;
    tcount_d   = tcount_q;
    en_d       = en_q;
    auto_d     = auto_q;
    pend_d     = pend_q;
    addr_err_d = addr_err_q;

    if (en_q) begin
      if (match) begin
        if (auto_q) tcount_d = 32'd0;
        else        en_d     = 1'b0;
      end else begin
        tcount_d = tcount_q + 32'd1;
      end
    end

    if (wr_io) begin
      case (io_sel)
        IO_LED:    led_d    = wd[15:0];
        IO_CYCLE:  cycle_d  = wd;
        IO_TCMP:   tcmp_d   = wd;
        IO_TCTRL: begin
          en_d   = wd[0];
          auto_d = wd[2];
          if (wd[1]) pend_d = 1'b0;
        end
        IO_TCOUNT: tcount_d = wd;
        IO_STATUS: if (wd[0]) addr_err_d = 1'b0;
        default:   ;
      endcase
    end

    if (match)  pend_d     = 1'b1;
    if (bad_wr) addr_err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      led_q      <= '0;
      cycle_q    <= '0;
      tcmp_q     <= '0;
      tcount_q   <= '0;
      en_q       <= 1'b0;
      pend_q     <= 1'b0;
      auto_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      led_q      <= led_d;
      cycle_q    <= cycle_d;
      tcmp_q     <= tcmp_d;
      tcount_q   <= tcount_d;
      en_q       <= en_d;
      pend_q     <= pend_d;
      auto_q     <= auto_d;
      addr_err_q <= addr_err_d;
    end
  end

  // RAM has no reset so its contents survive RST.
  always_ff @(posedge CLK) begin
    if (wr_ram) mem[ram_idx] <= wd;
  end

  always_comb begin
    bus.ReadData = 32'h0;
    if (ram_hit) begin
      bus.ReadData = mem[ram_idx];
    end else if (io_hit) begin
      case (io_sel)
        IO_LED:    bus.ReadData = {16'h0, led_q};
        IO_CYCLE:  bus.ReadData = cycle_q;
        IO_TCMP:   bus.ReadData = tcmp_q;
        IO_TCTRL:  bus.ReadData = {29'h0, auto_q, pend_q, en_q};
        IO_TCOUNT: bus.ReadData = tcount_q;
        IO_STATUS: bus.ReadData = {31'h0, addr_err_q};
        default:   bus.ReadData = 32'h0;
      endcase
    end
  end

  assign LED      = led_q;
  assign TimerIRQ = pend_q;
  assign AddrErr  = addr_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios then random traffic, all checked
// against a behavioural model of the memory map and timer rules.
module tb_data_mem_responder;
  logic        clk;
  logic        rst;
  logic [15:0] led;
  logic        irq;
  logic        aerr;
  int          n_pass = 0;
  int          n_total = 0;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(256), .IO_BASE(16'hFFFF)) dut (
    .CLK(clk), .RST(rst), .bus(bus), .LED(led), .TimerIRQ(irq), .AddrErr(aerr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model state
  logic [31:0] ram_m [int unsigned];
  logic [15:0] m_led;
  logic [31:0] m_cycle, m_tcmp, m_tcount;
  bit          m_en, m_pend, m_auto, m_aerr;

  task automatic model_reset();
    m_led = 0; m_cycle = 0; m_tcmp = 0; m_tcount = 0;
    m_en = 0; m_pend = 0; m_auto = 0; m_aerr = 0;
  endtask

  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    v = 32'h0;
    if (a < 32'd1024) begin
      if (!ram_m.exists(a >> 2)) return 1'b0;
      v = ram_m[a >> 2];
      return 1'b1;
    end
    if (a[31:16] != 16'hFFFF) return 1'b1;
    case ({a[15:2], 2'b00})
      16'h00: v = {16'h0, m_led};
      16'h04: v = m_cycle;
      16'h08: v = m_tcmp;
      16'h0C: v = {29'h0, m_auto, m_pend, m_en};
      16'h10: v = m_tcount;
      16'h14: v = {31'h0, m_aerr};
      default: v = 32'h0;
    endcase
    return 1'b1;
  endfunction

  task automatic model_edge(input bit we, input logic [31:0] a, input logic [31:0] d);
    bit hit, is_ram, is_io;
    hit = m_en && (m_tcount == m_tcmp);
    if (m_en) begin
      if (!hit) m_tcount = m_tcount + 1;
      else if (m_auto) m_tcount = 0;
      else m_en = 0;
    end
    if (hit) m_pend = 1;
    m_cycle = m_cycle + 1;
    if (we) begin
      is_ram = a < 32'd1024;
      is_io  = a[31:16] == 16'hFFFF;
      if (a[1:0] != 2'b00 || (!is_ram && !(is_io && a[15:0] <= 16'h14))) m_aerr = 1;
      else if (is_ram) ram_m[a >> 2] = d;
      else case (a[15:0])
        16'h00: m_led = d[15:0];
        16'h04: m_cycle = d;
        16'h08: m_tcmp = d;
        16'h0C: begin
          m_en = d[0]; m_auto = d[2];
          if (d[1] && !hit) m_pend = 0;
        end
        16'h10: m_tcount = d;
        16'h14: if (d[0]) m_aerr = 0;
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic probe(input string tag);
    logic [31:0] v;
    if (model_read(bus.ALUOut, v)) chk({tag, "_rd"}, bus.ReadData, v);
    chk({tag, "_led"}, {16'h0, led}, {16'h0, m_led});
    chk({tag, "_irq"}, {31'h0, irq}, {31'h0, m_pend});
    chk({tag, "_aerr"}, {31'h0, aerr}, {31'h0, m_aerr});
  endtask

  task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d, input string tag);
    bus.MemWrite = we; bus.ALUOut = a; bus.WriteData = d;
    #1 probe(tag);
    @(posedge clk);
    model_edge(we, a, d);
    #1;
  endtask

  task automatic rd_exp(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus.MemWrite = 1'b0; bus.ALUOut = a; bus.WriteData = 32'h0;
    #1 chk(tag, bus.ReadData, exp);
    probe(tag);
    @(posedge clk);
    model_edge(1'b0, a, 32'h0);
    #1;
  endtask

  task automatic in_reset_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus.MemWrite = 1'b0; bus.ALUOut = a; bus.WriteData = 32'h0;
    #1 chk(tag, bus.ReadData, exp);
  endtask

  initial begin
    logic [31:0] a, d;
    bit          we;
    int          sel;

    rst = 1'b0;
    bus.MemWrite = 1'b0; bus.ALUOut = 32'h0; bus.WriteData = 32'h0;
    model_reset();
    #2;
    chk("por_led", {16'h0, led}, 32'h0);
    chk("por_irq", {31'h0, irq}, 32'h0);
    chk("por_aerr", {31'h0, aerr}, 32'h0);
    in_reset_rd(32'hFFFF_0004, 32'h0, "por_cycle");
    in_reset_rd(32'hFFFF_000C, 32'h0, "por_tctrl");
    @(negedge clk) rst = 1'b1;

    // RAM write and unmapped read
    step(1, 32'h0000_0010, 32'hDEADBEEF, "w_ram");
    rd_exp(32'h0000_0010, 32'hDEADBEEF, "ram_rb");
    rd_exp(32'h8000_0000, 32'h0, "unmapped_rd");

    // bad writes, then clear
    step(1, 32'h0000_0012, 32'h1111_1111, "w_misal");
    chk("aerr_misal", {31'h0, aerr}, 32'h1);
    step(1, 32'h0000_0400, 32'h2222_2222, "w_unmap");
    rd_exp(32'h0000_0010, 32'hDEADBEEF, "ram_kept");
    step(1, 32'hFFFF_0014, 32'h1, "w_clr");
    chk("aerr_clr", {31'h0, aerr}, 32'h0);

    // LED and cycle counter
    step(1, 32'hFFFF_0000, 32'h1234_ABCD, "w_led");
    chk("led_out", {16'h0, led}, 32'h0000_ABCD);
    rd_exp(32'hFFFF_0000, 32'h0000_ABCD, "led_rb");
    step(0, 32'hFFFF_0004, 32'h0, "cyc_a");
    step(0, 32'hFFFF_0004, 32'h0, "cyc_b");
    step(1, 32'hFFFF_0004, 32'hFFFF_FFFE, "w_cyc");
    rd_exp(32'hFFFF_0004, 32'hFFFF_FFFE, "cyc_fe");
    rd_exp(32'hFFFF_0004, 32'hFFFF_FFFF, "cyc_ff");
    rd_exp(32'hFFFF_0004, 32'h0000_0000, "cyc_wrap");

    // one-shot timer
    step(1, 32'hFFFF_0008, 32'd3, "w_tcmp");
    step(1, 32'hFFFF_0010, 32'd0, "w_tcnt");
    step(1, 32'hFFFF_000C, 32'h1, "w_en");
    for (int i = 1; i <= 4; i++) begin
      step(0, 32'hFFFF_0010, 32'h0, "os_run");
      chk("os_irq", {31'h0, irq}, (i == 4) ? 32'h1 : 32'h0);
    end
    rd_exp(32'hFFFF_000C, 32'h2, "os_tctrl");
    rd_exp(32'hFFFF_0010, 32'd3, "os_hold1");
    rd_exp(32'hFFFF_0010, 32'd3, "os_hold2");

    // auto-reload timer, period 4
    step(1, 32'hFFFF_0010, 32'd0, "w_tcnt0");
    step(1, 32'hFFFF_000C, 32'h5, "w_auto");
    for (int k = 0; k <= 8; k++) rd_exp(32'hFFFF_0010, 32'(k % 4), "auto_cnt");
    chk("auto_irq", {31'h0, irq}, 32'h1);

    // W1C alone clears; W1C coinciding with a match leaves PEND set
    step(1, 32'hFFFF_0010, 32'd0, "w_tcnt0b");
    step(1, 32'hFFFF_000C, 32'h7, "w1c_plain");
    chk("w1c_irq0", {31'h0, irq}, 32'h0);
    step(0, 32'hFFFF_0010, 32'h0, "w1c_run1");
    step(0, 32'hFFFF_0010, 32'h0, "w1c_run2");
    step(1, 32'hFFFF_000C, 32'h7, "w1c_match");
    chk("w1c_set_wins", {31'h0, irq}, 32'h1);
    rd_exp(32'hFFFF_0010, 32'd0, "w1c_cnt");

    // asynchronous reset mid-count
    step(1, 32'h0000_0401, 32'h0, "w_bad2");
    step(1, 32'hFFFF_0010, 32'd2, "w_tcnt2");
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_aerr", {31'h0, aerr}, 32'h0);
    in_reset_rd(32'hFFFF_0010, 32'h0, "rst_tcount");
    in_reset_rd(32'hFFFF_000C, 32'h0, "rst_tctrl");
    in_reset_rd(32'hFFFF_0004, 32'h0, "rst_cycle");
    in_reset_rd(32'h0000_0010, 32'hDEADBEEF, "rst_ram_kept");
    @(posedge clk);
    #1 in_reset_rd(32'hFFFF_0004, 32'h0, "rst_cycle_held");
    @(negedge clk) rst = 1'b1;
    rd_exp(32'hFFFF_0004, 32'h0, "cyc_first");
    rd_exp(32'hFFFF_0004, 32'h1, "cyc_second");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 3)      a = 32'($urandom_range(0, 31)) << 2;
      else if (sel == 4) a = (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(1, 3));
      else if (sel == 5) a = 32'h0001_0000 + 32'($urandom_range(0, 1000));
      else if (sel <= 8) a = 32'hFFFF_0000 + (32'($urandom_range(0, 7)) << 2);
      else               a = 32'hFFFF_0000 + 32'($urandom_range(0, 23));
      if (a == 32'hFFFF_0008 || a == 32'hFFFF_0010) d = 32'($urandom_range(0, 6));
      else if (a == 32'hFFFF_000C)                  d = 32'($urandom_range(0, 7));
      else                                          d = $urandom;
      we = $urandom_range(0, 1) == 1;
      step(we, a, d, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder side of the single-cycle processor's data-memory port. It accepts the address, write data and write strobe driven by the core, and returns read data combinationally in the same cycle. It contains a word-addressed data RAM plus a small memory-mapped peripheral block: LED register, free-running cycle counter, compare timer with interrupt, and a sticky address-error flag. It sits beside the processor at the SoC top and is the only consumer of its data-memory outputs.

## Interface
- DEPTH_WORDS, 256: RAM depth in 32-bit words; power of two, 16..65536.
- IO_BASE, 16'hFFFF: upper address half-word selecting the peripheral region.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- MemWrite  in  1  write strobe from the core.
- ALUOut  in  32  byte address from the core.
- WriteData  in  32  store data from the core.
- ReadData  out  32  combinational read data for ALUOut.
- LED  out  16  LED register contents.
- TimerIRQ  out  1  timer pending flag, registered.
- AddrErr  out  1  sticky bad-write flag, registered.

## Operation
- Decode uses ALUOut:
  - RAM when ALUOut < DEPTH_WORDS*4, indexed by ALUOut[log2(DEPTH_WORDS)+1:2].
  - IO when ALUOut[31:16] == IO_BASE.
  - Anything else is unmapped.
- Reads are side-effect free. ALUOut is driven every cycle, including for non-memory instructions, so decoding a read must never change state. Reads ignore ALUOut[1:0].
- Read data by target:
  - RAM: the addressed word.
  - Unmapped: 32'h0.
  - Undefined IO offset: 32'h0.
- IO registers, by offset ALUOut[15:0]:
  - 0x00 LED: R/W, bits [15:0]; reads zero-extended.
  - 0x04 CYCLE: R/W; increments every cycle and wraps at 2^32.
  - 0x08 TCMP: R/W compare value.
  - 0x0C TCTRL:
    - bit0 EN, R/W.
    - bit1 PEND, read; write 1 clears.
    - bit2 AUTO, R/W.
    - Other bits read 0.
  - 0x10 TCOUNT: R/W timer count.
  - 0x14 STATUS: bit0 AddrErr, read; write 1 clears.
- Writes occur when MemWrite = 1 on the rising edge.
  - A write is bad if ALUOut[1:0] != 0, or the address is unmapped, or it hits an undefined IO offset.
  - A bad write is suppressed, changes no state, and sets AddrErr.
- Timer, evaluated each cycle with EN = 1:
  - If TCOUNT == TCMP: PEND <= 1. If AUTO = 1, TCOUNT <= 0 and EN stays 1. If AUTO = 0, TCOUNT holds and EN <= 0 (one-shot).
  - Otherwise TCOUNT <= TCOUNT + 1, wrapping at 2^32.
  - With EN = 0, TCOUNT holds.
- TimerIRQ = PEND. AddrErr output = STATUS bit0.

## Timing
- Read latency is 0 cycles: ReadData is a pure combinational function of ALUOut and current state.
- Write latency is 1 edge: the new value is visible on ReadData the cycle after the write.
- Reset (RST low, asynchronous) clears LED, CYCLE, TCMP, TCTRL, TCOUNT and AddrErr to 0. Outputs LED = 0, TimerIRQ = 0, AddrErr = 0.
- RAM is not reset; its contents are preserved across reset. Reading an unwritten word is undefined.
- Reset asserted mid-count stops the timer immediately. The first CYCLE increment is on the first edge after RST deasserts.
- Simultaneous-event rules:
  - A write to CYCLE loads WriteData and suppresses that cycle's increment. The next edge increments from the loaded value.
  - A write to TCOUNT overrides both the increment and the match action for that cycle. The match against the old value is still evaluated for PEND.
  - A PEND write-1-clear in the same cycle as a new match: set wins, so PEND = 1.
  - A TCTRL write updates EN/AUTO. If it coincides with a one-shot match, the written EN wins.
  - An AddrErr clear in the same cycle as a new bad write: set wins.
- CYCLE wrap: 32'hFFFF_FFFF -> 32'h0 with no flag.

## Test plan
- Reset, then write 32'hDEADBEEF to 0x0000_0010. Next cycle ReadData at 0x10 = 32'hDEADBEEF; ReadData at 0x8000_0000 = 0.
- Write to 0x0000_0012 (misaligned) and to 0x0000_0400 with DEPTH_WORDS = 256 (unmapped). RAM is unchanged and AddrErr = 1. Write 1 to 0xFFFF_0014: AddrErr = 0 next cycle.
- Write LED = 32'h1234_ABCD: LED = 16'hABCD, read-back = 32'h0000_ABCD. Read 0xFFFF_0004 on successive cycles: values differ by exactly 1.
- Write CYCLE = 32'hFFFF_FFFE, then read for 3 cycles: FFFF_FFFE, FFFF_FFFF, 0000_0000.
- One-shot timer: TCMP = 3, TCOUNT = 0, TCTRL = 3'b001. TimerIRQ rises 4 edges after the enable write, EN reads 0, TCOUNT holds 3. In auto mode (TCTRL = 3'b101): IRQ pending, count returns to 0 and period is 4 cycles. A W1C on PEND issued in the same cycle as a fresh match leaves TimerIRQ = 1.
- Drive RST low mid-count with TCOUNT = 2: all registers and outputs are 0 immediately (asynchronously); a previously written RAM word still reads back.
